microwave_timer: RTL and testbench

//  Microwave cook-time countdown in BCD, shown as M:ST (minutes, seconds tens, seconds ones).

---
 rtl/microwave_timer_pkg.sv | 22 ++
 rtl/microwave_timer_if.sv | 33 +++
 rtl/microwave_timer_bcd_down_digit.sv | 48 ++++
 rtl/microwave_timer.sv | 80 ++++++++
 tb/tb_microwave_timer.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/microwave_timer_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : timer_pkg
//  Description : Shared BCD digit type and digit constants for the microwave
//                cook-time countdown, plus a digit legality helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package timer_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX       = 4'd9;
  localparam bcd_t SEC_TENS_WRAP = 4'd5;
  localparam bcd_t BCD_ZERO      = 4'd0;

  // Keypad codes above 9 are not decimal digits and must not be shifted in.
  function automatic logic is_bcd(input bcd_t d);
    return (d <= BCD_MAX);
  endfunction

endpackage : timer_pkg
`default_nettype wire

// File: rtl/microwave_timer_if.sv
`default_nettype none
// ============================================================================
//  Interface   : microwave_timer_if
//  Description : Keypad/tick inputs and M:ST display outputs of the timer.
//                master : drives in/loadn/en, observes the digits and zero
//                slave  : the timer itself
//  Signals     : in[3:0] keypad digit, loadn active-low load, en 1 s tick,
//                sec_ones/sec_tens/mins BCD digits, zero expiry flag
//  Revision    : 1.0 - initial release
// ============================================================================
interface microwave_timer_if;
  import timer_pkg::*;

  bcd_t in;
  logic loadn;
  logic en;
  bcd_t sec_ones;
  bcd_t sec_tens;
  bcd_t mins;
  logic zero;

  modport master (
    output in, loadn, en,
    input  sec_ones, sec_tens, mins, zero
  );

  modport slave (
    input  in, loadn, en,
    output sec_ones, sec_tens, mins, zero
  );

endinterface : microwave_timer_if
`default_nettype wire

// File: rtl/microwave_timer_bcd_down_digit.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_down_digit
//  Description : One 4-bit BCD digit register that can be shift-loaded or
//                decremented with borrow chaining.
//  Ports       : clk, rst (sync, active-high)
//                i_shift/i_load_val : load the digit (shift-in path)
//                i_dec/i_borrow_in  : step down when both are high
//                i_wrap             : value taken when stepping down from 0
//                o_digit            : registered digit
//                o_borrow_out       : digit is 0 (next slice must step too)
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_down_digit
  import timer_pkg::*;
(
  input  wire  clk,
  input  wire  rst,
  input  wire  i_shift,
  input  bcd_t i_load_val,
  input  wire  i_dec,
  input  wire  i_borrow_in,
  input  bcd_t i_wrap,
  output bcd_t o_digit,
  output logic o_borrow_out
);

  bcd_t r_digit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_digit <= BCD_ZERO;
    end else if (i_shift) begin
      r_digit <= i_load_val;
    end else if (i_dec && i_borrow_in) begin
      if (r_digit == BCD_ZERO) begin
        r_digit <= i_wrap;
      end else begin
        r_digit <= r_digit - 4'd1;
      end
    end
  end

  assign o_digit      = r_digit;
  assign o_borrow_out = (r_digit == BCD_ZERO);

endmodule : bcd_down_digit
`default_nettype wire

// File: rtl/microwave_timer.sv
`default_nettype none
// ============================================================================
//  Module      : microwave_timer
//  Description : M:ST BCD cook-time countdown. Digits shift in from the keypad
//                while loadn is low, then count down one second per en tick,
//                saturating at 0:00.
//  Ports       : clock      system clock, rising edge
//                clr        sync active-high reset / user cancel
//                bus        microwave_timer_if.slave (in, loadn, en,
//                           sec_ones, sec_tens, mins, zero)
//  Revision    : 1.0 - initial release
// ============================================================================
module microwave_timer
  import timer_pkg::*;
(
  input  wire                      clock,
  input  wire                      clr,
  microwave_timer_if.slave         bus
);

  bcd_t w_ones;
  bcd_t w_tens;
  bcd_t w_mins;
  logic w_ones_zero;
  logic w_tens_zero;
  logic w_mins_zero;
  logic w_zero;
  logic w_shift;
  logic w_dec;

  // Load outranks count; an illegal key freezes all digits for that edge.
  assign w_shift = !bus.loadn && is_bcd(bus.in);
  // Gating with !zero is what makes 0:00 saturate instead of wrapping.
  assign w_dec   = bus.loadn && bus.en && !w_zero;
  assign w_zero  = w_ones_zero && w_tens_zero && w_mins_zero;

  bcd_down_digit u_ones (
    .clk          (clock),
    .rst          (clr),
    .i_shift      (w_shift),
    .i_load_val   (bus.in),
    .i_dec        (w_dec),
    .i_borrow_in  (1'b1),
    .i_wrap       (BCD_MAX),
    .o_digit      (w_ones),
    .o_borrow_out (w_ones_zero)
  );

  bcd_down_digit u_tens (
    .clk          (clock),
    .rst          (clr),
    .i_shift      (w_shift),
    .i_load_val   (w_ones),
    .i_dec        (w_dec),
    .i_borrow_in  (w_ones_zero),
    .i_wrap       (SEC_TENS_WRAP),
    .o_digit      (w_tens),
    .o_borrow_out (w_tens_zero)
  );

  // Minutes never wrap in practice: decrement is blocked once all digits are 0.
  bcd_down_digit u_mins (
    .clk          (clock),
    .rst          (clr),
    .i_shift      (w_shift),
    .i_load_val   (w_tens),
    .i_dec        (w_dec),
    .i_borrow_in  (w_ones_zero && w_tens_zero),
    .i_wrap       (BCD_MAX),
    .o_digit      (w_mins),
    .o_borrow_out (w_mins_zero)
  );

  assign bus.sec_ones = w_ones;
  assign bus.sec_tens = w_tens;
  assign bus.mins     = w_mins;
  assign bus.zero     = w_zero;

endmodule : microwave_timer
`default_nettype wire

// File: tb/tb_microwave_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_microwave_timer
//  Description : Directed self-checking bench for microwave_timer. Display
//                values are compared as 12-bit {mins,sec_tens,sec_ones},
//                e.g. 12'h199 is 1:99.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_microwave_timer;

  logic clock;
  logic clr;
  int   r_checks;
  int   r_failures;

  microwave_timer_if u_if ();

  microwave_timer u_dut (
    .clock (clock),
    .clr   (clr),
    .bus   (u_if.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [11:0] act, input logic [11:0] exp);
    r_checks++;
    if (act !== exp) begin
      r_failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [11:0] disp();
    return {u_if.mins, u_if.sec_tens, u_if.sec_ones};
  endfunction

  // Advance one edge; outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic key(input logic [3:0] d);
    u_if.loadn = 1'b0;
    u_if.en    = 1'b0;
    u_if.in    = d;
    tick();
    u_if.loadn = 1'b1;
  endtask

  task automatic load3(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    key(a);
    key(b);
    key(c);
  endtask

  task automatic count(input int n);
    u_if.loadn = 1'b1;
    u_if.en    = 1'b1;
    ticks(n);
    u_if.en    = 1'b0;
  endtask

  initial begin
    r_checks   = 0;
    r_failures = 0;
    clr        = 1'b1;
    u_if.in    = 4'd0;
    u_if.loadn = 1'b1;
    u_if.en    = 1'b0;
    #2;
    tick();
    clr = 1'b0;
    chk("reset_disp", disp(), 12'h000);
    chk("reset_zero", {11'd0, u_if.zero}, 12'h001);

    count(2);
    chk("idle_count_disp", disp(), 12'h000);
    chk("idle_count_zero", {11'd0, u_if.zero}, 12'h001);

    load3(4'd1, 4'd9, 4'd9);
    chk("load_199", disp(), 12'h199);
    chk("load_199_zero", {11'd0, u_if.zero}, 12'h000);

    count(1);
    chk("count_198", disp(), 12'h198);
    count(98);
    chk("count_100", disp(), 12'h100);
    count(1);
    chk("min_borrow_059", disp(), 12'h059);

    // Clear mid-count at 0:50 (109 steps from 1:99).
    load3(4'd1, 4'd9, 4'd9);
    count(109);
    chk("reach_050", disp(), 12'h050);
    clr        = 1'b1;
    u_if.en    = 1'b1;
    tick();
    clr        = 1'b0;
    chk("clr_mid_count", disp(), 12'h000);
    chk("clr_zero", {11'd0, u_if.zero}, 12'h001);
    count(3);
    chk("after_clr_hold", disp(), 12'h000);

    load3(4'd0, 4'd1, 4'd0);
    chk("load_010", disp(), 12'h010);
    count(1);
    chk("tens_borrow_009", disp(), 12'h009);
    load3(4'd2, 4'd0, 4'd0);
    chk("load_200", disp(), 12'h200);
    count(1);
    chk("full_borrow_159", disp(), 12'h159);

    u_if.loadn = 1'b1;
    u_if.en    = 1'b0;
    ticks(5);
    chk("pause_hold", disp(), 12'h159);

    key(4'd12);
    chk("illegal_key", disp(), 12'h159);
    key(4'd15);
    chk("illegal_key_f", disp(), 12'h159);

    load3(4'd0, 4'd0, 4'd1);
    chk("load_001", disp(), 12'h001);
    count(1);
    chk("count_to_000", disp(), 12'h000);
    count(2);
    chk("saturate_000", disp(), 12'h000);
    chk("saturate_zero", {11'd0, u_if.zero}, 12'h001);

    // Load and enable together: shift only.
    u_if.loadn = 1'b0;
    u_if.en    = 1'b1;
    u_if.in    = 4'd3;
    tick();
    chk("load_beats_en", disp(), 12'h003);
    u_if.in    = 4'd5;
    tick();
    chk("load_beats_en2", disp(), 12'h035);

    // Clear beats load.
    clr        = 1'b1;
    u_if.in    = 4'd7;
    tick();
    clr        = 1'b0;
    u_if.loadn = 1'b1;
    u_if.en    = 1'b0;
    chk("clr_beats_load", disp(), 12'h000);

    key(4'd4);
    key(4'd4);
    key(4'd4);
    key(4'd4);
    chk("oldest_dropped_444", disp(), 12'h444);
    count(1);
    chk("count_443", disp(), 12'h443);

    $display("TB_RESULT checks=%0d failures=%0d", r_checks, r_failures);
    $finish;
  end

endmodule : tb_microwave_timer
`default_nettype wire
